// File: rtl/gin_mcc_fifo.sv
// gin_mcc_fifo: tag/mask multicast filter feeding a DEPTH-entry FIFO toward one consumer
module gin_mcc_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [TAG_WIDTH-1:0]  cfg_id,
  input  logic [TAG_WIDTH-1:0]  cfg_mask,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  enable_out,
  input  logic                  ready_in,
  output logic [CNT_WIDTH-1:0]  pkt_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [AW:0]           r_count;
  logic [TAG_WIDTH-1:0]  r_id, r_mask;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic                  w_match, w_full, w_empty, w_push, w_pop;
  assign w_match    = ((tag ^ r_id) & r_mask) == '0;
  assign w_full     = r_count == (AW+1)'(DEPTH);
  assign w_empty    = r_count == '0;
  assign ready_out  = !w_match || !w_full;
  assign w_push     = enable_in && w_match && !w_full;
  assign w_pop      = !w_empty && ready_in;
  assign enable_out = !w_empty;
  assign data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign pkt_count  = r_pkt_count;
  // Destination ID and compare mask; a load only affects matching from the next cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_id   <= '1;
      r_mask <= '1;
    end else if (cfg_load) begin
      r_id   <= cfg_id;
      r_mask <= cfg_mask;
    end
  // FIFO pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // Payload storage; contents are don't-care until written
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  // Delivered-packet counter, restarted by any configuration load
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pkt_count <= '0;
    else r_pkt_count <= cfg_load ? '0 : r_pkt_count + CNT_WIDTH'(w_pop);
endmodule

// File: tb/tb_gin_mcc_fifo.sv
// tb_gin_mcc_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_gin_mcc_fifo;
  localparam int DW = 16, TW = 4, DEPTH = 4, CW = 4;
  typedef struct {
    logic cl;
    logic [TW-1:0] id, mask, tag;
    logic [DW-1:0] data;
    logic en, rdy;
  } in_t;
  typedef struct {
    logic ro, eo;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 0, reset = 1, cfg_load = 0, enable_in = 0, ready_in = 0;
  logic [TW-1:0] cfg_id = 0, cfg_mask = 0, tag = 0;
  logic [DW-1:0] data_in = 0;
  logic ready_out, enable_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] pkt_count;

  gin_mcc_fifo #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .tag(tag), .data_in(data_in), .enable_in(enable_in), .ready_out(ready_out),
    .data_out(data_out), .enable_out(enable_out), .ready_in(ready_in), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] mq[$];
  logic [TW-1:0] m_id = '1, m_mask = '1;
  logic [CW-1:0] m_cnt = 0;
  vec_t tbl[20];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask

  function automatic in_t mk_in(logic cl, logic [TW-1:0] id, logic [TW-1:0] mask, logic [TW-1:0] t,
                                logic [DW-1:0] d, logic en, logic rdy);
    in_t r;
    r.cl = cl; r.id = id; r.mask = mask; r.tag = t; r.data = d; r.en = en; r.rdy = rdy;
    return r;
  endfunction

  function automatic vec_t mk(logic cl, logic [TW-1:0] id, logic [TW-1:0] mask, logic [TW-1:0] t,
                              logic [DW-1:0] d, logic en, logic rdy,
                              logic ro, logic eo, logic [DW-1:0] od, logic [CW-1:0] cnt);
    vec_t r;
    r.i = mk_in(cl, id, mask, t, d, en, rdy);
    r.o.ro = ro; r.o.eo = eo; r.o.d = od; r.o.cnt = cnt;
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_id = '1; m_mask = '1; m_cnt = 0;
  endfunction

  // One cycle: drive at edge+1, sample at the falling edge, then advance the model across the edge
  task automatic step(input in_t i, input bit use_tbl, input out_t e, output bit acc);
    out_t m, x;
    bit match, pop, push;
    cfg_load = i.cl; cfg_id = i.id; cfg_mask = i.mask; tag = i.tag;
    data_in = i.data; enable_in = i.en; ready_in = i.rdy;
    match = ((i.tag ^ m_id) & m_mask) == 0;
    m.ro = !match || mq.size() < DEPTH;
    m.eo = mq.size() != 0;
    m.d = mq.size() != 0 ? mq[0] : '0;
    m.cnt = m_cnt;
    if (use_tbl) x = e; else x = m;
    #4;
    chk("ready_out", ready_out, x.ro);
    chk("enable_out", enable_out, x.eo);
    chk("data_out", data_out, x.d);
    chk("pkt_count", pkt_count, x.cnt);
    acc = i.en && m.ro;
    pop = m.eo && i.rdy;
    push = i.en && match && mq.size() < DEPTH;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(i.data);
    m_cnt = i.cl ? '0 : m_cnt + CW'(pop);
    if (i.cl) begin m_id = i.id; m_mask = i.mask; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    out_t z;
    bit acc;
    z = '{default: 0};
    step(mk_in(0, 0, 0, 0, 0, 0, rdy), 0, z, acc);
  endtask

  task automatic load(input logic [TW-1:0] id, input logic [TW-1:0] mask, input logic rdy);
    out_t z;
    bit acc;
    z = '{default: 0};
    step(mk_in(1, id, mask, 0, 0, 0, rdy), 0, z, acc);
  endtask

  // Hold a packet until the model says it is accepted (bounded)
  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic rdy);
    out_t z;
    bit acc;
    int k;
    z = '{default: 0};
    k = 0;
    do begin
      step(mk_in(0, 0, 0, t, d, 1, rdy), 0, z, acc);
      k++;
    end while (!acc && k < 20);
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout tag %0h data %0h: not accepted after %0d cycles", t, d, k);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && mq.size() != 0; k++) idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    out_t z;
    z = '{default: 0};
    tbl[0]  = mk(0, 0, 0, 4'hF, 16'h0011, 1, 0, 1, 0, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 1, 16'h0011, 0);
    tbl[2]  = mk(1, 3, 4'hF, 4'h0, 16'h0000, 0, 1, 1, 0, 16'h0000, 1);
    tbl[3]  = mk(0, 0, 0, 4'h3, 16'h000A, 1, 1, 1, 0, 16'h0000, 0);
    tbl[4]  = mk(0, 0, 0, 4'h5, 16'h000B, 1, 1, 1, 1, 16'h000A, 0);
    tbl[5]  = mk(0, 0, 0, 4'h3, 16'h000C, 1, 1, 1, 0, 16'h0000, 1);
    tbl[6]  = mk(0, 0, 0, 4'h3, 16'h0000, 0, 1, 1, 1, 16'h000C, 1);
    tbl[7]  = mk(0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 0, 16'h0000, 2);
    tbl[8]  = mk(1, 4, 4'hC, 4'h0, 16'h0000, 0, 1, 1, 0, 16'h0000, 2);
    tbl[9]  = mk(0, 0, 0, 4'h4, 16'h0040, 1, 1, 1, 0, 16'h0000, 0);
    tbl[10] = mk(0, 0, 0, 4'h5, 16'h0050, 1, 1, 1, 1, 16'h0040, 0);
    tbl[11] = mk(0, 0, 0, 4'h6, 16'h0060, 1, 1, 1, 1, 16'h0050, 1);
    tbl[12] = mk(0, 0, 0, 4'h7, 16'h0070, 1, 1, 1, 1, 16'h0060, 2);
    tbl[13] = mk(0, 0, 0, 4'h8, 16'h0080, 1, 1, 1, 1, 16'h0070, 3);
    tbl[14] = mk(0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 16'h0000, 4);
    tbl[15] = mk(1, 4, 4'h0, 4'h0, 16'h0000, 0, 1, 1, 0, 16'h0000, 4);
    tbl[16] = mk(0, 0, 0, 4'h9, 16'h0090, 1, 1, 1, 0, 16'h0000, 0);
    tbl[17] = mk(0, 0, 0, 4'h2, 16'h0020, 1, 1, 1, 1, 16'h0090, 0);
    tbl[18] = mk(0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 1, 16'h0020, 1);
    tbl[19] = mk(0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 0, 16'h0000, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_enable_out", enable_out, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_pkt_count", pkt_count, 0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    model_reset();

    foreach (tbl[k]) step(tbl[k].i, 1, tbl[k].o, acc);

    // Back-pressure: four accepted, fifth stalls, non-matching still accepted
    load(4'h7, 4'hF, 1);
    for (int k = 0; k < 4; k++) send(4'h7, 16'hD000 + 16'(k), 0);
    step(mk_in(0, 0, 0, 4'h7, 16'hD004, 1, 0), 0, z, acc);
    chk("full_ready_out", ready_out, 0);
    step(mk_in(0, 0, 0, 4'h1, 16'hEEEE, 1, 0), 0, z, acc);
    chk("full_nonmatch_accepted", acc, 1);
    step(mk_in(0, 0, 0, 4'h7, 16'hD004, 1, 1), 0, z, acc);
    chk("full_pop_no_push", acc, 0);
    step(mk_in(0, 0, 0, 4'h7, 16'hD004, 1, 1), 0, z, acc);
    chk("recover_push", acc, 1);
    send(4'h7, 16'hD005, 1);
    drain();

    // Pointer wrap and counter wrap over 20 packets
    load(4'hA, 4'hF, 1);
    for (int k = 0; k < 20; k++) send(4'hA, 16'h0100 + 16'(k), k % 2 == 0);
    drain();
    chk("pkt_count_wrap", pkt_count, 4);

    // Reconfigure with packets buffered: they still drain, counter restarts
    for (int k = 0; k < 3; k++) send(4'hA, 16'h0200 + 16'(k), 0);
    step(mk_in(1, 4'hB, 4'hF, 4'hA, 16'h0203, 1, 0), 0, z, acc);
    step(mk_in(0, 0, 0, 4'hA, 16'h0204, 1, 0), 0, z, acc);
    chk("old_id_discard", acc, 1);
    drain();
    chk("pkt_count_after_load", pkt_count, 4);
    send(4'hB, 16'h0300, 1);
    drain();

    // Reset between edges with three packets buffered
    for (int k = 0; k < 3; k++) send(4'hB, 16'h0400 + 16'(k), 0);
    #1 reset = 1;
    #1;
    chk("async_reset_enable_out", enable_out, 0);
    chk("async_reset_data_out", data_out, 0);
    chk("async_reset_pkt_count", pkt_count, 0);
    model_reset();
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    send(4'hE, 16'h0E0E, 0);
    send(4'hF, 16'h0F0F, 0);
    idle(1);
    idle(1);

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      logic [TW-1:0] t;
      t = ($urandom % 2) ? m_id : TW'($urandom);
      step(mk_in($urandom % 20 == 0, TW'($urandom), ($urandom % 4 == 0) ? '0 : TW'($urandom), t,
                 DW'($urandom), $urandom % 4 != 0, $urandom % 3 != 0), 0, z, acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
